simple_dual_port_ram_fifo_controller: RTL and testbench

Single-clock FIFO controller that sits in front of the simple dual-port RAM and drives both of its ports. Upstream producers push words through a write-enable/full interface; downstream consumers pop words through a first-word-fall-through valid/ready interface. The controller owns the pointers, the full and occupancy flags, the RAM read latency (0 or 1 cycle) and a 2-entry output buffer that sustains one word per cycle.

---
 rtl/simple_dual_port_ram_fifo_controller.sv | 166 ++++++++++++++++
 tb/tb_simple_dual_port_ram_fifo_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_dual_port_ram_fifo_controller.sv
`default_nettype none
// ============================================================================
// Module   : simple_dual_port_ram_fifo_controller
// Brief    : Single-clock FIFO controller for a simple dual-port RAM. It
//            owns the pointers and the full flag, and handles 0- or 1-cycle
//            RAM read latency. A 2-entry first-word-fall-through output
//            buffer sustains one pop per cycle.
//            Optional macro SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
//            adds a registered 'level' output (total stored words).
// Revision : 1.0 - initial release
// ============================================================================
module simple_dual_port_ram_fifo_controller #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 16,
    parameter int REGISTERED_READ = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       write_enable,
    input  logic [WIDTH-1:0]           write_data,
    output logic                       full,
    output logic                       read_valid,
    input  logic                       read_ready,
    output logic [WIDTH-1:0]           read_data,
    output logic                       ram_write_enable,
    output logic [$clog2(DEPTH)-1:0]   ram_write_address,
    output logic [WIDTH-1:0]           ram_write_data,
    output logic                       ram_read_enable,
    output logic [$clog2(DEPTH)-1:0]   ram_read_address,
    input  logic [WIDTH-1:0]           ram_read_data
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+3)-1:0] level
`endif
);

    localparam int             c_AW         = $clog2(DEPTH);
    // Occupancy value meaning "RAM full"; DEPTH is a power of two.
    localparam logic [c_AW:0]  c_DEPTH_PTR  = {1'b1, {c_AW{1'b0}}};

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [1:0]         r_buf_count;
    logic [WIDTH-1:0]   r_buf0;
    logic [WIDTH-1:0]   r_buf1;

    logic [c_AW:0]      w_occupancy;
    logic               w_push;
    logic               w_pop;
    logic               w_fetch;
    logic               w_capture;
    logic               w_in_flight;
    logic [2:0]         w_pending;

    assign w_occupancy = r_wr_ptr - r_rd_ptr;
    assign full        = (w_occupancy == c_DEPTH_PTR);
    assign read_valid  = (r_buf_count != 2'd0);
    assign read_data   = r_buf0;

    // Words already promised to the output buffer once this cycle's pop leaves.
    assign w_pending = {1'b0, r_buf_count} + {2'b00, w_in_flight} - {2'b00, w_pop};

    // Enables are gated with reset so the RAM sees no traffic while it is held.
    assign w_push  = write_enable & ~full & ~reset;
    assign w_pop   = read_valid & read_ready;
    assign w_fetch = (w_occupancy != '0) && (w_pending < 3'd2) && !reset;

    assign ram_write_enable  = w_push;
    assign ram_write_address = r_wr_ptr[c_AW-1:0];
    assign ram_write_data    = write_data;
    assign ram_read_enable   = w_fetch;
    assign ram_read_address  = r_rd_ptr[c_AW-1:0];

    generate
        if (REGISTERED_READ != 0) begin : g_registered_read
            logic r_in_flight;

            // Track the one outstanding RAM read; its data lands next cycle.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_in_flight <= 1'b0;
                end else begin
                    r_in_flight <= w_fetch;
                end
            end

            assign w_in_flight = r_in_flight;
            assign w_capture   = r_in_flight;
        end else begin : g_combinational_read
            assign w_in_flight = 1'b0;
            assign w_capture   = w_fetch;
        end
    endgenerate

    // Write and read pointers; the MSB is the wrap bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Two-entry in-order output buffer; r_buf0 is always the head.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf_count <= 2'd0;
            r_buf0      <= '0;
            r_buf1      <= '0;
        end else begin
            case ({w_pop, w_capture})
                2'b01: begin
                    if (r_buf_count == 2'd0) begin
                        r_buf0 <= ram_read_data;
                    end else begin
                        r_buf1 <= ram_read_data;
                    end
                    r_buf_count <= r_buf_count + 2'd1;
                end
                2'b10: begin
                    // A lone remaining head stays in r_buf0 so read_data holds.
                    if (r_buf_count == 2'd2) begin
                        r_buf0 <= r_buf1;
                    end
                    r_buf_count <= r_buf_count - 2'd1;
                end
                2'b11: begin
                    if (r_buf_count == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= ram_read_data;
                    end else begin
                        r_buf0 <= ram_read_data;
                    end
                end
                default: begin
                    r_buf_count <= r_buf_count;
                end
            endcase
        end
    end

`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
    localparam int c_LW = $clog2(DEPTH+3);
    logic [c_LW-1:0] r_level;

    // Fetches only move words between RAM, in-flight and buffer, so only
    // accepted pushes and pops change the total.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= r_level + c_LW'(w_push) - c_LW'(w_pop);
        end
    end

    assign level = r_level;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_dual_port_ram_fifo_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_dual_port_ram_fifo_controller
// Brief    : Directed self-checking bench for the FIFO controller with a
//            behavioural registered-read RAM (DEPTH=16, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_dual_port_ram_fifo_controller;

    localparam int c_WIDTH = 8;
    localparam int c_DEPTH = 16;
    localparam int c_AW    = 4;

    logic                clock;
    logic                reset;
    logic                write_enable;
    logic [c_WIDTH-1:0]  write_data;
    logic                full;
    logic                read_valid;
    logic                read_ready;
    logic [c_WIDTH-1:0]  read_data;
    logic                ram_write_enable;
    logic [c_AW-1:0]     ram_write_address;
    logic [c_WIDTH-1:0]  ram_write_data;
    logic                ram_read_enable;
    logic [c_AW-1:0]     ram_read_address;
    logic [c_WIDTH-1:0]  ram_read_data;
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
    logic [4:0]          level;
`endif

    logic [c_WIDTH-1:0]  r_mem [0:c_DEPTH-1];
    logic [c_WIDTH-1:0]  q [$];
    int                  errors = 0;
    int                  checks = 0;
    int                  pops   = 0;

    simple_dual_port_ram_fifo_controller #(
        .WIDTH           (c_WIDTH),
        .DEPTH           (c_DEPTH),
        .REGISTERED_READ (1)
    ) u_dut (
        .clock             (clock),
        .reset             (reset),
        .write_enable      (write_enable),
        .write_data        (write_data),
        .full              (full),
        .read_valid        (read_valid),
        .read_ready        (read_ready),
        .read_data         (read_data),
        .ram_write_enable  (ram_write_enable),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_read_enable   (ram_read_enable),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data)
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
        ,
        .level             (level)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural simple dual-port RAM with one-cycle registered read.
    always_ff @(posedge clock) begin
        if (ram_write_enable) r_mem[ram_write_address] <= ram_write_data;
        if (ram_read_enable)  ram_read_data <= r_mem[ram_read_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One cycle: drive inputs, check/model the push and pop, then clock.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic rr);
        write_enable = we;
        write_data   = wd;
        read_ready   = rr;
        #1;
        check("push_accept", ram_write_enable, we && !full);
        if (we && !full) q.push_back(wd);
        if (rr && read_valid) begin
            pops++;
            if (q.size() == 0) check("pop_unexpected", 1, 0);
            else               check("pop_data", read_data, q.pop_front());
        end
        step();
    endtask

    initial begin
        int gaps;
        int nfull;
        reset        = 1'b1;
        write_enable = 1'b1;
        write_data   = 8'hFF;
        read_ready   = 1'b0;
        step();
        step();
        #1;
        check("rst_wr_en_held", ram_write_enable, 0);
        check("rst_rd_en_held", ram_read_enable, 0);
        write_enable = 1'b0;
        reset = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            check("idle_full", full, 0);
            check("idle_valid", read_valid, 0);
            check("idle_data", read_data, 0);
            check("idle_wr_en", ram_write_enable, 0);
            check("idle_rd_en", ram_read_enable, 0);
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
            check("idle_level", level, 0);
`endif
            step();
        end

        // Single push of 0xA5 with read_ready=0
        write_enable = 1'b1;
        write_data   = 8'hA5;
        #1;
        check("push_wr_en", ram_write_enable, 1);
        check("push_wr_addr", ram_write_address, 0);
        check("push_wr_data", ram_write_data, 8'hA5);
        q.push_back(8'hA5);
        step();
        write_enable = 1'b0;
        #1;
        check("e0_rd_en", ram_read_enable, 1);
        check("e0_rd_addr", ram_read_address, 0);
        check("e0_valid", read_valid, 0);
        step();
        check("e1_valid", read_valid, 0);
        check("e1_rd_en", ram_read_enable, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", read_valid, 1);
            check("hold_data", read_data, 8'hA5);
            step();
        end
        cyc(1'b0, 8'h00, 1'b1);
        check("pop_valid_low", read_valid, 0);
        check("pop_data_held", read_data, 8'hA5);

        // Fill with read_ready=0, pushing 0..19
        for (int i = 0; i < c_DEPTH + 4; i++) begin
            write_enable = 1'b1;
            write_data   = 8'(i);
            read_ready   = 1'b0;
            #1;
            check("fill_full", full, i >= 18);
            check("fill_accept", ram_write_enable, i < 18);
            if (ram_write_enable) q.push_back(8'(i));
            step();
        end
        write_enable = 1'b0;
        #1;
        check("filled_full", full, 1);
        check("filled_valid", read_valid, 1);
        check("filled_head", read_data, 0);
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
        check("filled_level", level, 18);
`endif
        pops = 0;
        for (int i = 0; i < 30 && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
        check("drain_count", pops, 18);
        check("drain_empty_valid", read_valid, 0);
        check("drain_full", full, 0);
`ifdef SIMPLE_DUAL_PORT_RAM_FIFO_CONTROLLER_LEVEL_EN
        check("drain_level", level, 0);
`endif

        // Streaming 1000 words, push and ready every cycle
        pops  = 0;
        gaps  = 0;
        nfull = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i >= 3 && !read_valid) gaps++;
            if (full) nfull++;
            cyc(1'b1, 8'(i * 7 + 3), 1'b1);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);
        check("stream_pops", pops, 1000);
        check("stream_gaps", gaps, 0);
        check("stream_full", nfull, 0);
        check("stream_left", q.size(), 0);

        // Random push/ready at 50% each
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
        check("rand_left", q.size(), 0);
        check("rand_valid", read_valid, 0);

        // Reset with one fetch in flight
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        #1;
        check("mrst_valid", read_valid, 0);
        check("mrst_full", full, 0);
        check("mrst_rd_en", ram_read_enable, 0);
        step();
        check("mrst_no_capture", read_valid, 0);
        cyc(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 6 && !read_valid; i++) cyc(1'b0, 8'h00, 1'b0);
        check("mrst_valid_after", read_valid, 1);
        check("mrst_first_word", read_data, 8'h3C);
        cyc(1'b0, 8'h00, 1'b1);
        #1;
        check("mrst_empty", read_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
